// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit, one bit per cycle.
//   Multiply: radix-2 shift-add on operand magnitudes into a 2*XLEN product.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle.
//   The sign of the result is applied at the end.
//   A start accepted in cycle 0 produces its result in cycle XLEN+1.
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   start, kill           request (sampled in IDLE), synchronous abort
//   funct3                000 MUL 001 MULH 010 MULHSU 011 MULHU
//                         100 DIV 101 DIVU 110 REM 111 REMU
//   rs1_data, rs2_data    operands, captured on the accepting edge
//   rd_in                 destination register index
//   busy                  high in CALC and DONE
//   done, RegWrite        one-cycle result pulse / register-file write enable
//   rd, write_data        write index and result; held outside DONE
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // Latched request: op, destination and the result sign decisions.
  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rd;
    logic       q_neg;   // negate product / quotient
    logic       r_neg;   // negate remainder (sign of dividend)
    logic       b_zero;  // divisor was zero
  } req_t;

  state_t          state;
  req_t            req;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi;   // mul: product high half; div: partial remainder
  logic [XLEN-1:0] lo;   // mul: multiplier/product low; div: dividend/quotient
  logic [XLEN-1:0] bop;  // mul: multiplicand magnitude; div: divisor magnitude

  // Operand conditioning at start. MUL is handled unsigned: its low
  // half does not depend on signedness.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
  end

  // One iteration of either algorithm.
  logic            is_div;
  logic [XLEN:0]   sum, sh, diff;
  logic [XLEN-1:0] nhi, nlo;

  always_comb begin
    is_div = req.op[2];
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, bop} : {(XLEN+1){1'b0}});
    sh     = {hi, lo[XLEN-1]};
    diff   = sh - {1'b0, bop};
    if (is_div) begin
      // diff[XLEN] set means the trial subtraction borrowed: restore.
      if (!diff[XLEN]) begin
        nhi = diff[XLEN-1:0];
        nlo = {lo[XLEN-2:0], 1'b1};
      end else begin
        nhi = sh[XLEN-1:0];
        nlo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Add-then-shift-right keeps the carry as the new product MSB.
      nhi = sum[XLEN:1];
      nlo = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Result from the final iteration's outputs, so it is ready on the
  // edge that enters DONE.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, result;

  always_comb begin
    prod   = {nhi, nlo};
    prod_s = req.q_neg ? -prod : prod;
    // Divide by zero leaves |rs1| as remainder; only the quotient needs
    // forcing, since a negated all-ones would be wrong.
    quo    = req.b_zero ? {XLEN{1'b1}} : (req.q_neg ? -nlo : nlo);
    rem    = req.r_neg ? -nhi : nhi;
    if (is_div)
      result = req.op[1] ? rem : quo;
    else
      result = (req.op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req        <= '0;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      bop        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      RegWrite   <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            state      <= CALC;
            busy       <= 1'b1;
            cnt        <= '0;
            req.op     <= funct3;
            req.rd     <= rd_in;
            req.q_neg  <= a_neg ^ b_neg;
            req.r_neg  <= a_neg;
            req.b_zero <= (rs2_data == '0);
            hi         <= '0;
            lo         <= a_mag;
            bop        <= b_mag;
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state      <= DONE;
              done       <= 1'b1;
              RegWrite   <= (req.rd != 5'd0);
              rd         <= req.rd;
              write_data <= result;
            end
          end
        end
        DONE: begin
          // Leaves unconditionally; kill here has the same effect.
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          RegWrite <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): directed vectors, randomized operations
// against an arithmetic reference model, back-to-back, kill and reset aborts.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .kill(kill),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .RegWrite(RegWrite), .rd(rd),
    .write_data(write_data)
  );

  // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ps;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin ps = sa * sb; pu = ps; return pu[63:32]; end
      3'd2: begin ps = sa * longint'({32'b0, b}); pu = ps; return pu[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb; pu = ps; return pu[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        ps = sa % sb; pu = ps; return pu[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge and observe cycles 1..XLEN+2. Operand and
  // control inputs are scrambled right after the accepting edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, output int dcyc, output int dcnt,
                        output logic [31:0] wd, output logic [4:0] rdo,
                        output logic rw, output int cbad);
    dcyc = -1; dcnt = 0; wd = '0; rdo = '0; rw = 1'b0; cbad = 0;
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
    funct3 = 3'($urandom); rd_in = 5'($urandom);
    for (int c = 1; c <= XLEN + 2; c++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        dcnt++; dcyc = c; wd = write_data; rdo = rd; rw = RegWrite;
      end else if (RegWrite !== 1'b0) cbad++;
      if (busy !== (c <= XLEN + 1)) cbad++;
    end
  endtask

  // Issue one op, then kill at kill_c or pull reset at rst_c; watch 40 cycles.
  task automatic abort_run(input int kill_c, input int rst_c, output int ndone,
                           output int nbusy, output int nrst);
    int stop;
    ndone = 0; nbusy = 0; nrst = 0;
    stop = (kill_c < rst_c) ? kill_c : rst_c;
    funct3 = 3'b000; rs1_data = 32'd1234; rs2_data = 32'd99; rd_in = 5'd9;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done !== 1'b0 || RegWrite !== 1'b0) ndone++;
      if (busy !== (c <= stop)) nbusy++;
      if (c == kill_c) kill = 1'b1;
      if (c == kill_c + 1) kill = 1'b0;
      if (c == rst_c) begin
        reset_n = 1'b0;
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || RegWrite !== 1'b0 ||
            rd !== 5'd0 || write_data !== 32'd0) nrst++;
      end
      if (c == rst_c + 1) reset_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    int dcyc, dcnt, cbad; logic [31:0] wd; logic [4:0] rdo; logic rw;
    reset_n = 1'b0; start = 1'b1; rs1_data = 32'd5; rs2_data = 32'd5; rd_in = 5'd1;
    repeat (3) @(negedge clock);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite got %b want 0", RegWrite); end
    n_vec++; if (rd !== 5'd0) begin n_err++; $display("FAIL rst_rd got %0d want 0", rd); end
    n_vec++; if (write_data !== 32'd0) begin n_err++; $display("FAIL rst_wd got %h want 0", write_data); end
    // First start is taken on the first rising edge after release.
    reset_n = 1'b1;
    run_op(3'b000, 32'd5, 32'd5, 5'd1, dcyc, dcnt, wd, rdo, rw, cbad);
    n_vec++; if (dcyc !== 33 || dcnt !== 1) begin n_err++;
      $display("FAIL first_start_lat got cyc %0d cnt %0d want 33 1", dcyc, dcnt); end
    n_vec++; if (wd !== 32'd25) begin n_err++; $display("FAIL first_start_wd got %h want 19", wd); end
  endtask

  task automatic test_directed();
    logic [2:0]  df [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0};
    logic [31:0] da [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'd3};
    logic [31:0] db [11] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd0,
                             32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
    logic [4:0]  dr [11] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd10, 5'd11, 5'd0};
    logic [31:0] de [11] = '{32'h2A, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h64, 32'h80000000, 32'h0, 32'h9};
    int dcyc, dcnt, cbad; logic [31:0] wd; logic [4:0] rdo; logic rw;
    for (int i = 0; i < 11; i++) begin
      run_op(df[i], da[i], db[i], dr[i], dcyc, dcnt, wd, rdo, rw, cbad);
      n_vec++; if (wd !== de[i]) begin n_err++;
        $display("FAIL dir%0d_wd got %h want %h", i, wd, de[i]); end
      n_vec++; if (dcyc !== 33 || dcnt !== 1) begin n_err++;
        $display("FAIL dir%0d_lat got cyc %0d cnt %0d want 33 1", i, dcyc, dcnt); end
      n_vec++; if (rw !== (dr[i] != 5'd0) || rdo !== dr[i]) begin n_err++;
        $display("FAIL dir%0d_wr got rw %b rd %0d want rw %b rd %0d", i, rw, rdo, dr[i] != 5'd0, dr[i]); end
      n_vec++; if (cbad !== 0) begin n_err++;
        $display("FAIL dir%0d_ctrl got %0d busy/RegWrite errors want 0", i, cbad); end
    end
  endtask

  task automatic test_random();
    int dcyc, dcnt, cbad; logic [31:0] wd, a, b, exp; logic [4:0] rdo, r; logic rw; logic [2:0] f;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom); a = pick(); b = pick(); r = 5'($urandom);
      exp = ref_model(f, a, b);
      run_op(f, a, b, r, dcyc, dcnt, wd, rdo, rw, cbad);
      n_vec++; if (wd !== exp) begin n_err++;
        $display("FAIL rand_wd op=%0d a=%h b=%h got %h want %h", f, a, b, wd, exp); end
      n_vec++; if (dcyc !== 33 || dcnt !== 1 || cbad !== 0) begin n_err++;
        $display("FAIL rand_timing got cyc %0d cnt %0d ctrl %0d want 33 1 0", dcyc, dcnt, cbad); end
      n_vec++; if (rw !== (r != 5'd0) || rdo !== r) begin n_err++;
        $display("FAIL rand_wr got rw %b rd %0d want rw %b rd %0d", rw, rdo, r != 5'd0, r); end
    end
  endtask

  task automatic test_back_to_back();
    int dq[$]; logic [31:0] vq[$]; int blow[$];
    logic [31:0] e1, e2;
    e1 = ref_model(3'd5, 32'd1000, 32'd7);
    e2 = ref_model(3'd6, 32'hFFFFFF9C, 32'd7);
    funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clock); #1;
    funct3 = 3'd6; rs1_data = 32'hFFFFFF9C; rs2_data = 32'd7; rd_in = 5'd4;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clock);
      if (done === 1'b1) begin dq.push_back(c); vq.push_back(write_data); end
      if (busy !== 1'b1) blow.push_back(c);
    end
    start = 1'b0;
    n_vec++; if (dq.size() != 2 || dq[0] != 33 || dq[1] != 67) begin n_err++;
      $display("FAIL b2b_done got %0d pulses first %0d want 2 at 33,67", dq.size(),
               (dq.size() > 0) ? dq[0] : -1); end
    n_vec++; if (blow.size() != 1 || blow[0] != 34) begin n_err++;
      $display("FAIL b2b_busy got %0d idle cycles first %0d want 1 at 34", blow.size(),
               (blow.size() > 0) ? blow[0] : -1); end
    n_vec++; if (vq.size() != 2 || vq[0] !== e1 || vq[1] !== e2) begin n_err++;
      $display("FAIL b2b_wd got %h %h want %h %h", (vq.size() > 0) ? vq[0] : 32'hx,
               (vq.size() > 1) ? vq[1] : 32'hx, e1, e2); end
    @(negedge clock);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy got %b want 0", busy); end
  endtask

  task automatic test_kill();
    int dcyc, dcnt, cbad, nd, nb, nr; logic [31:0] wd; logic [4:0] rdo; logic rw;
    // Leave a nonzero result in the output registers for the reset check.
    run_op(3'b000, 32'd7, 32'd6, 5'd5, dcyc, dcnt, wd, rdo, rw, cbad);
    n_vec++; if (wd !== 32'h2A || rdo !== 5'd5) begin n_err++;
      $display("FAIL kill_pre got wd %h rd %0d want 2a 5", wd, rdo); end
    abort_run(10, 1000, nd, nb, nr);
    n_vec++; if (nd !== 0 || nb !== 0) begin n_err++;
      $display("FAIL kill_c10 got done %0d busyerr %0d want 0 0", nd, nb); end
    n_vec++; if (rd !== 5'd5 || write_data !== 32'h2A) begin n_err++;
      $display("FAIL kill_hold got rd %0d wd %h want 5 2a", rd, write_data); end
    abort_run(32, 1000, nd, nb, nr);
    n_vec++; if (nd !== 0 || nb !== 0) begin n_err++;
      $display("FAIL kill_last got done %0d busyerr %0d want 0 0", nd, nb); end
    abort_run(1000, 5, nd, nb, nr);
    n_vec++; if (nd !== 0 || nb !== 0) begin n_err++;
      $display("FAIL rst_mid got done %0d busyerr %0d want 0 0", nd, nb); end
    n_vec++; if (nr !== 0) begin n_err++;
      $display("FAIL rst_mid_outs got %0d nonzero want 0", nr); end
    // Kill in IDLE blocks a simultaneous start.
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd1;
    @(negedge clock);
    start = 1'b0; kill = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill_idle got busy %b want 0", busy); end
    run_op(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd17, dcyc, dcnt, wd, rdo, rw, cbad);
    n_vec++; if (wd !== ref_model(3'b001, 32'h12345678, 32'h9ABCDEF0) || dcyc !== 33 || dcnt !== 1) begin
      n_err++; $display("FAIL after_abort got wd %h cyc %0d want %h 33", wd, dcyc,
                        ref_model(3'b001, 32'h12345678, 32'h9ABCDEF0)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
